mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter sharing the single 64-bit memory port of the multi-cycle RV64 core between instruction fetch (IFU) and load/store (MEMU). It performs round-robin grant and keeps one transaction outstanding on the downstream bus. It registers each request payload at grant and returns data with a one-cycle `*_done` pulse. The control unit consumes that pulse as its `ifu_finish` / `memu_finish`.

## Interface
Parameters:
- `ADDR_W`, 64, address width on all ports.
- `DATA_W`, 64, downstream data width; fixed at 64 in this core.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  IFU fetch request; held with stable `i_addr` until `i_done`.
- `i_addr`  in  ADDR_W  fetch address, 4-byte aligned.
- `i_rdata`  out  32  fetched instruction.
- `i_done`  out  1  one-cycle completion pulse for IFU.
- `i_err`  out  1  bus error on the IFU transaction; valid with `i_done`.
- `d_req`  in  1  MEMU request; held with stable payload until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  64  store data.
- `d_wstrb`  in  8  store byte enables.
- `d_rdata`  out  64  load data.
- `d_done`  out  1  one-cycle completion pulse for MEMU.
- `d_err`  out  1  bus error on the MEMU transaction; valid with `d_done`.
- `m_valid`  out  1  downstream request valid.
- `m_ready`  in  1  downstream accepts the request.
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb`  out  1/ADDR_W/64/8  downstream request payload.
- `m_rvalid`  in  1  downstream response valid; also acknowledges writes.
- `m_rdata`  in  64  response data.
- `m_err`  in  1  response error; valid with `m_rvalid`.

## Operation
- States:
  - `IDLE`: no grant; accepts new requests.
  - `ADDR`: `m_valid`=1 with registered payload; waits for `m_ready`.
  - `RESP`: waits for `m_rvalid`.
  - `DONE`: the granted requester's `*_done` is 1 for exactly this cycle.
- Transitions:
  - `IDLE`→`ADDR` when `i_req|d_req`.
  - `ADDR`→`RESP` on `m_ready`.
  - `RESP`→`DONE` on `m_rvalid`.
  - `DONE`→`IDLE` unconditionally.
- Arbitration in `IDLE` is two-way round-robin on `last_grant`:
  - If both requests are high, grant the requester that was not granted last.
  - If only one request is high, grant it.
  - `last_grant` updates on entry to `ADDR`.
- Payload registers load on `IDLE`→`ADDR`. An IFU grant forces `m_we`=0, `m_wstrb`=0, `m_wdata`=0.
- Response registers load on `m_rvalid` in `RESP`:
  - `d_rdata` = `m_rdata`.
  - `i_rdata` = `m_addr[2] ? m_rdata[63:32] : m_rdata[31:0]`.
  - `*_err` = `m_err`.
- `*_rdata` and `*_err` hold their values until the next response.
- Requesters drop `*_req` in the cycle after `*_done`. The `DONE` state exists so that a `*_req` still high during the pulse cycle is never re-granted.
- `m_rvalid` is ignored outside `RESP`, including stale responses after reset. The downstream bus returns `m_rvalid` no earlier than the cycle after the `m_valid&&m_ready` handshake.
- Requester payload changes after grant are ignored because the payload is registered.

## Timing
- Reset values while `rst`=0 (applied immediately):
  - state=`IDLE`.
  - `m_valid`=0, `i_done`=`d_done`=0, `i_err`=`d_err`=0.
  - `i_rdata`=0, `d_rdata`=0, `m_*` payload=0.
  - `last_grant`=IFU, so the first tie goes to MEMU.
- Minimum latency:
  - `req` high at cycle 0.
  - `m_valid` at cycle 1; with `m_ready` at cycle 1, `m_rvalid` at cycle 2.
  - `*_done` at cycle 3.
- `m_valid` and payload stay stable from `ADDR` entry until `m_ready`. The arbiter never withdraws a request.
- Back-to-back: the next grant is at the earliest in the `IDLE` cycle after `DONE`. Peak throughput is one transaction per 4 cycles.
- Reset mid-transaction: the arbiter abandons the transaction. No `*_done` is produced for it.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_t` (`IDLE`, `ADDR`, `RESP`, `DONE`).
  - `grant_t` (`GNT_I`, `GNT_D`).
  - Width constants `ADDR_W` and `DATA_W`.
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs are `req[1:0]` and `last`; outputs are `gnt` and `any`. The `last_grant` flop stays in `mem_arbiter`.

## Test plan
- IFU only, `i_addr`=0x8000_0004, `m_ready`=1 immediately, `m_rdata`=0x1111_2222_3333_4444 one cycle later -> `i_done` at cycle 3, `i_rdata`=0x1111_2222, `m_we`=0.
- Both requests in the same cycle after reset -> MEMU granted first. IFU is granted in the first `IDLE` after `d_done`. A second simultaneous tie then goes to MEMU again, alternating.
- MEMU store `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_wstrb`=0x0F, `m_ready` stalled 3 cycles -> `m_valid` and payload stable for 4 cycles; `d_done` 2 cycles after `m_ready`.
- `m_rvalid` with `m_err`=1 on a load -> `d_err`=1 with `d_done`; the next clean transaction clears it.
- `rst` asserted while in `RESP`, then `m_rvalid` pulsed after release -> no `*_done`, state `IDLE`, `m_valid`=0.
- `d_req` held high through `DONE` then dropped -> exactly one downstream transaction issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/MEMU memory-port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned INSN_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // Pick the 32-bit instruction word out of a 64-bit beat by address bit 2.
   function automatic logic [INSN_W-1:0] insn_sel(input logic hi, input logic [DATA_W-1:0] beat);
      return hi ? beat[DATA_W-1:INSN_W] : beat[INSN_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; bit 0 is IFU, bit 1 is MEMU.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last,
   output grant_t     gnt,
   output logic       any
);

   // On a tie favour whoever was not granted last; otherwise the lone requester.
   always_comb begin
      gnt = GNT_I;
      any = |req;
      if (&req) begin
         gnt = (last == GNT_I) ? GNT_D : GNT_I;
      end else if (req[1]) begin
         gnt = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single 64-bit memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with a one-cycle done pulse per requester.
module mem_arbiter #(
   parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
)(
   input  logic                clk,
   input  logic                rst,

   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [31:0]         i_rdata,
   output logic                i_done,
   output logic                i_err,

   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                d_err,

   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_err
);

   import mem_arb_pkg::*;

   localparam int unsigned STRB_W = DATA_W / 8;

   arb_state_t state;
   grant_t     last_grant;
   grant_t     pick;
   logic       pick_any;

   rr_arb2 u_rr (
      .req  ({d_req, i_req}),
      .last (last_grant),
      .gnt  (pick),
      .any  (pick_any)
   );

   // Transaction FSM; last_grant doubles as the owner of the in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GNT_I;
         m_valid    <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         i_err      <= 1'b0;
         d_err      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  state      <= ADDR;
                  last_grant <= pick;
                  m_valid    <= 1'b1;
                  if (pick == GNT_D) begin
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     m_wstrb <= d_wstrb;
                  end else begin
                     m_we    <= 1'b0;
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                     m_wstrb <= STRB_W'(0);
                  end
               end
            end
            ADDR: begin
               if (m_ready) begin
                  state   <= RESP;
                  m_valid <= 1'b0;
               end
            end
            RESP: begin
               if (m_rvalid) begin
                  state <= DONE;
                  if (last_grant == GNT_D) begin
                     d_rdata <= m_rdata;
                     d_err   <= m_err;
                     d_done  <= 1'b1;
                  end else begin
                     i_rdata <= insn_sel(m_addr[2], m_rdata);
                     i_err   <= m_err;
                     i_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Pulse cycle; a request still held here must not be re-granted.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
